// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, register-0 constant and source-select enum for the write-back port
package wb_pkg;

    localparam int DSIZE = 16;
    localparam int RSIZE = 4;
    localparam int NREG  = 16;

    localparam logic [RSIZE-1:0] R0 = '0;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_LD,
        SRC_ALU
    } src_t;

endpackage

// File: rtl/wb_write_port_if.sv
// rtl/wb_write_port_if.sv - result-source bundle (load return and ALU result) feeding the write-back port
interface wb_write_port_if
    import wb_pkg::*;
#(
    parameter int DW = DSIZE,
    parameter int AW = RSIZE
);

    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;

    modport master (
        output ld_valid, ld_addr, ld_data,
        output alu_valid, alu_addr, alu_data,
        input  alu_ready
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data,
        input  alu_valid, alu_addr, alu_data,
        output alu_ready
    );

endinterface

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - outstanding-write busy vector with claim/clear and operand stall generation
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             claim_valid,
    input  logic [RSIZE-1:0] claim_addr,
    input  logic             clr_valid,
    input  logic [RSIZE-1:0] clr_addr,
    input  logic [RSIZE-1:0] q_addr1,
    input  logic [RSIZE-1:0] q_addr2,
    input  logic             q_hit1,
    input  logic             q_hit2,
    output logic             q_stall1,
    output logic             q_stall2,
    output logic [NREG-1:0]  busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_busy_nxt;

    // Clear is applied before set so a same-edge claim keeps the register reserved.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (clr_valid && clr_addr != R0)
            w_clr[clr_addr] = 1'b1;
        if (claim_valid && claim_addr != R0)
            w_set[claim_addr] = 1'b1;
        w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~NREG'(1);
    end

    always_ff @(posedge Clock) begin
        if (!Reset)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign busy     = r_busy;
    assign q_stall1 = r_busy[q_addr1] & ~q_hit1;
    assign q_stall2 = r_busy[q_addr2] & ~q_hit2;

endmodule

// File: rtl/wb_write_port.sv
// rtl/wb_write_port.sv - load/ALU write-back arbiter, write stage and bypass; WB_PERF_CNT_EN adds perf counters
module wb_write_port
    import wb_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    wb_write_port_if.slave   bus,
    input  logic             claim_valid,
    input  logic [RSIZE-1:0] claim_addr,
    input  logic [RSIZE-1:0] q_addr1,
    input  logic [RSIZE-1:0] q_addr2,
    output logic             q_hit1,
    output logic             q_hit2,
    output logic [DSIZE-1:0] q_data1,
    output logic [DSIZE-1:0] q_data2,
    output logic             q_stall1,
    output logic             q_stall2,
    output logic [NREG-1:0]  busy,
    output logic             Wen,
    output logic [RSIZE-1:0] WAddr,
    output logic [DSIZE-1:0] WData
`ifdef WB_PERF_CNT_EN
    ,
    output logic [DSIZE-1:0] perf_writes,
    output logic [DSIZE-1:0] perf_alu_stalls
`endif
);

    src_t             w_src;
    logic [RSIZE-1:0] w_addr;
    logic [DSIZE-1:0] w_data;
    logic             w_acc;
    logic             w_wr;

    logic             r_wen;
    logic [RSIZE-1:0] r_waddr;
    logic [DSIZE-1:0] r_wdata;

    // Loads cannot be back-pressured, so they always win the single port.
    always_comb begin
        w_src = SRC_NONE;
        if (bus.ld_valid)
            w_src = SRC_LD;
        else if (bus.alu_valid)
            w_src = SRC_ALU;
    end

    assign bus.alu_ready = bus.alu_valid & ~bus.ld_valid;
    assign w_addr        = (w_src == SRC_LD) ? bus.ld_addr : bus.alu_addr;
    assign w_data        = (w_src == SRC_LD) ? bus.ld_data : bus.alu_data;
    assign w_acc         = (w_src != SRC_NONE);
    assign w_wr          = w_acc && (w_addr != R0);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_wr;
            if (w_acc) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
            end
        end
    end

    assign Wen   = r_wen;
    assign WAddr = r_waddr;
    assign WData = r_wdata;

    assign q_hit1  = r_wen & (r_waddr == q_addr1) & (q_addr1 != R0);
    assign q_hit2  = r_wen & (r_waddr == q_addr2) & (q_addr2 != R0);
    assign q_data1 = q_hit1 ? r_wdata : '0;
    assign q_data2 = q_hit2 ? r_wdata : '0;

    wb_scoreboard u_scoreboard (
        .Clock       (Clock),
        .Reset       (Reset),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .clr_valid   (w_wr),
        .clr_addr    (w_addr),
        .q_addr1     (q_addr1),
        .q_addr2     (q_addr2),
        .q_hit1      (q_hit1),
        .q_hit2      (q_hit2),
        .q_stall1    (q_stall1),
        .q_stall2    (q_stall2),
        .busy        (busy)
    );

`ifdef WB_PERF_CNT_EN
    logic [DSIZE-1:0] r_perf_writes;
    logic [DSIZE-1:0] r_perf_alu_stalls;
    logic             w_alu_stall;

    assign w_alu_stall = bus.alu_valid & ~bus.alu_ready;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_perf_writes     <= '0;
            r_perf_alu_stalls <= '0;
        end else begin
            if (r_wen && r_perf_writes != '1)
                r_perf_writes <= r_perf_writes + 1'b1;
            if (w_alu_stall && r_perf_alu_stalls != '1)
                r_perf_alu_stalls <= r_perf_alu_stalls + 1'b1;
        end
    end

    assign perf_writes     = r_perf_writes;
    assign perf_alu_stalls = r_perf_alu_stalls;
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// tb/tb_wb_write_port.sv - directed plus randomized check of wb_write_port against a behavioural model
module tb_wb_write_port;
    import wb_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        claim_valid;
    logic [3:0]  claim_addr;
    logic [3:0]  q_addr1, q_addr2;
    logic        q_hit1, q_hit2;
    logic [15:0] q_data1, q_data2;
    logic        q_stall1, q_stall2;
    logic [15:0] busy;
    logic        Wen;
    logic [3:0]  WAddr;
    logic [15:0] WData;
`ifdef WB_PERF_CNT_EN
    logic [15:0] perf_writes, perf_alu_stalls;
`endif

    always #5 Clock = ~Clock;

    wb_write_port_if bus ();

    wb_write_port dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .bus         (bus.slave),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .q_addr1     (q_addr1),
        .q_addr2     (q_addr2),
        .q_hit1      (q_hit1),
        .q_hit2      (q_hit2),
        .q_data1     (q_data1),
        .q_data2     (q_data2),
        .q_stall1    (q_stall1),
        .q_stall2    (q_stall2),
        .busy        (busy),
        .Wen         (Wen),
        .WAddr       (WAddr),
        .WData       (WData)
`ifdef WB_PERF_CNT_EN
        ,
        .perf_writes     (perf_writes),
        .perf_alu_stalls (perf_alu_stalls)
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Model state: the write currently on the port, reserved registers, counters.
    bit          m_wen;
    bit [3:0]    m_waddr;
    bit [15:0]   m_wdata;
    bit          m_busy [16];
    int unsigned m_pw, m_ps;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        for (int k = 0; k < 16; k++) m_busy[k] = 1'b0;
        m_pw = 0;
        m_ps = 0;
    endtask

    function automatic bit exp_hit(input bit [3:0] q);
        return m_wen && (m_waddr == q) && (q != 0);
    endfunction

    // Apply one cycle of inputs, compare everything visible, advance the model across the edge.
    task automatic step(input bit rn, input bit lv, input bit [3:0] la, input bit [15:0] ldd,
                        input bit av, input bit [3:0] aa, input bit [15:0] ad,
                        input bit cv, input bit [3:0] ca, input bit [3:0] qa1, input bit [3:0] qa2);
        logic [15:0] eb;
        bit          acc;
        bit [3:0]    a;
        bit [15:0]   d;
        Reset         = rn;
        bus.ld_valid  = lv;
        bus.ld_addr   = la;
        bus.ld_data   = ldd;
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        claim_valid   = cv;
        claim_addr    = ca;
        q_addr1       = qa1;
        q_addr2       = qa2;
        #1;
        for (int k = 0; k < 16; k++) eb[k] = m_busy[k];
        check("alu_ready", 32'(bus.alu_ready), 32'(av && !lv));
        check("Wen", 32'(Wen), 32'(m_wen));
        if (m_wen) begin
            check("WAddr", 32'(WAddr), 32'(m_waddr));
            check("WData", 32'(WData), 32'(m_wdata));
        end
        check("busy", 32'(busy), 32'(eb));
        check("q_hit1", 32'(q_hit1), 32'(exp_hit(qa1)));
        check("q_hit2", 32'(q_hit2), 32'(exp_hit(qa2)));
        check("q_data1", 32'(q_data1), exp_hit(qa1) ? 32'(m_wdata) : 32'd0);
        check("q_data2", 32'(q_data2), exp_hit(qa2) ? 32'(m_wdata) : 32'd0);
        check("q_stall1", 32'(q_stall1), 32'(m_busy[qa1] && !exp_hit(qa1)));
        check("q_stall2", 32'(q_stall2), 32'(m_busy[qa2] && !exp_hit(qa2)));
`ifdef WB_PERF_CNT_EN
        check("perf_writes", 32'(perf_writes), m_pw);
        check("perf_alu_stalls", 32'(perf_alu_stalls), m_ps);
`endif
        if (!rn) begin
            model_reset();
        end else begin
            if (m_wen && m_pw != 32'hFFFF) m_pw++;
            if (av && lv && m_ps != 32'hFFFF) m_ps++;
            acc = lv || av;
            a   = lv ? la : aa;
            d   = lv ? ldd : ad;
            m_wen = acc && (a != 0);
            if (acc) begin
                m_waddr = a;
                m_wdata = d;
            end
            if (m_wen) m_busy[a] = 1'b0;
            if (cv && ca != 0) m_busy[ca] = 1'b1;
        end
        @(negedge Clock);
    endtask

    initial begin
        bit        rn, lv, av, cv, a_hold;
        bit [3:0]  la, aa, ca, q1, q2;
        bit [15:0] ldd, ad;

        Reset = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        claim_valid = 1'b0; claim_addr = '0; q_addr1 = '0; q_addr2 = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        model_reset();
        check("rst_Wen", 32'(Wen), 32'd0);
        check("rst_WAddr", 32'(WAddr), 32'd0);
        check("rst_WData", 32'(WData), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single ALU write
        step(1, 0, 0, 0, 1, 3, 16'h1234, 0, 0, 3, 0);
        check("t1_Wen", 32'(Wen), 32'd1);
        check("t1_WAddr", 32'(WAddr), 32'd3);
        check("t1_WData", 32'(WData), 32'h1234);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t1_Wen_off", 32'(Wen), 32'd0);

        // Contention: load first, ALU holds and follows
        step(1, 1, 5, 16'hAAAA, 1, 6, 16'h5555, 0, 0, 5, 6);
        check("t2_WAddr_ld", 32'(WAddr), 32'd5);
        check("t2_WData_ld", 32'(WData), 32'hAAAA);
        step(1, 0, 0, 0, 1, 6, 16'h5555, 0, 0, 5, 6);
        check("t2_WAddr_alu", 32'(WAddr), 32'd6);
        check("t2_WData_alu", 32'(WData), 32'h5555);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Scoreboard and bypass on r7
        step(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        check("t3_busy7", 32'(busy[7]), 32'd1);
        check("t3_stall", 32'(q_stall1), 32'd1);
        step(1, 1, 7, 16'h0F0F, 0, 0, 0, 0, 0, 7, 0);
        check("t3_hit", 32'(q_hit1), 32'd1);
        check("t3_qdata", 32'(q_data1), 32'h0F0F);
        check("t3_nostall", 32'(q_stall1), 32'd0);
        check("t3_busy7_clr", 32'(busy[7]), 32'd0);

        // Claim wins over same-edge clear
        step(1, 0, 0, 0, 1, 4, 16'h4444, 1, 4, 4, 0);
        check("t4_busy4", 32'(busy[4]), 32'd1);

        // Register 0 writes and claims are inert
        step(1, 0, 0, 0, 1, 0, 16'hFFFF, 1, 0, 0, 0);
        check("t5_Wen", 32'(Wen), 32'd0);
        check("t5_busy0", 32'(busy[0]), 32'd0);
        check("t5_hit0", 32'(q_hit1), 32'd0);

        // Reset while a write to r9 is on the port
        step(1, 0, 0, 0, 1, 9, 16'h9999, 1, 9, 0, 0);
        check("t6_Wen", 32'(Wen), 32'd1);
        step(0, 0, 0, 0, 1, 2, 16'h2222, 1, 2, 9, 0);
        check("t6_Wen_rst", 32'(Wen), 32'd0);
        check("t6_busy_rst", 32'(busy), 32'd0);
`ifdef WB_PERF_CNT_EN
        check("t6_pw_rst", 32'(perf_writes), 32'd0);
        check("t6_ps_rst", 32'(perf_alu_stalls), 32'd0);
`endif

        // Randomized traffic with ALU hold-until-accepted
        a_hold = 1'b0;
        av = 1'b0; aa = '0; ad = '0;
        for (int i = 0; i < 3000; i++) begin
            rn  = ($urandom_range(0, 99) != 0);
            lv  = ($urandom_range(0, 99) < 30);
            la  = 4'($urandom_range(0, 7));
            ldd = 16'($urandom);
            if (!a_hold) begin
                av = ($urandom_range(0, 99) < 60);
                aa = 4'($urandom_range(0, 7));
                ad = 16'($urandom);
            end
            cv = ($urandom_range(0, 99) < 30);
            ca = 4'($urandom_range(0, 7));
            q1 = 4'($urandom_range(0, 7));
            q2 = 4'($urandom_range(0, 7));
            step(rn, lv, la, ldd, av, aa, ad, cv, ca, q1, q2);
            a_hold = rn && av && lv;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
